// File: rtl/mem_ctrl_ram.sv
// mem_ctrl_ram: word-addressed synchronous RAM with programmable wait states,
// byte-lane writes and a busy/done handshake. Define MEM_BOUNDS_CHECK_EN for the fault port.
module mem_ctrl_ram #(
    parameter int    DATA_W      = 32,
    parameter int    ADDR_W      = 32,
    parameter int    DEPTH       = 512,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   Mdatain,
`ifdef MEM_BOUNDS_CHECK_EN
    output logic                fault,
`endif
    output logic [DATA_W-1:0]   Q,
    output logic                busy,
    output logic                done
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;

    state_t              state, state_nx;
    logic [3:0]          cnt;
    logic [IDX_W-1:0]    lat_idx;
    logic [DATA_W-1:0]   lat_data;
    logic [BYTES-1:0]    lat_be;
    logic                lat_wr;
    logic                lat_oob;
    logic                addr_oob;
    logic                req;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    assign addr_oob = (address >> IDX_W) != '0;
`else
    logic unused_addr_hi;
    assign addr_oob       = 1'b0;
    assign unused_addr_hi = ^(address >> IDX_W);
`endif

    assign req = read | write;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req) state_nx = (WAIT_CYCLES == 0) ? S_ACC : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nx = S_ACC;
            S_ACC:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Request capture, wait counter and registered read data / done pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt      <= '0;
            lat_idx  <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            lat_wr   <= 1'b0;
            lat_oob  <= 1'b0;
            Q        <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    lat_idx  <= address[IDX_W-1:0];
                    lat_data <= Mdatain;
                    lat_be   <= be;
                    lat_wr   <= write;
                    lat_oob  <= addr_oob;
                    cnt      <= 4'(WAIT_CYCLES);
                end
                S_WAIT: cnt <= cnt - 4'd1;
                S_ACC: begin
                    done <= 1'b1;
                    if (!lat_wr) Q <= lat_oob ? '0 : mem[lat_idx];
                end
                default: ;
            endcase
        end
    end

    // clr gating keeps a reset landing on the access edge from committing the write.
    always_ff @(posedge clk) begin
        if (state == S_ACC && lat_wr && !lat_oob && clr) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) fault <= 1'b0;
        else      fault <= (state == S_ACC) && lat_oob;
    end
`endif

endmodule
